sha2_multiblock_core: RTL and testbench

Streaming, multi-block SHA-2 compression engine for the EdDSA hash path. It accepts pre-padded 16-word message blocks over a valid/ready word interface and chains any number of blocks per message. A compile-time UNROLL factor sets how many rounds run per clock, and the truncated digest is presented with a one-cycle valid strobe. The caller supplies the padding; this block contains no padding logic.

---
 rtl/sha2_multiblock_core.sv | 209 ++++++++++++++++++++
 tb/tb_sha2_multiblock_core.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_multiblock_core.sv
// Multi-block SHA-2 compression engine (224/256/384/512, 512/224, 512/256).
// Takes pre-padded 16-word blocks over valid/ready, runs UNROLL rounds per
// clock, and presents the truncated digest with a one-cycle valid strobe.
//
// state    | meaning
// S_IDLE   | waiting for word 0 of a block
// S_LOAD   | words 1..15 of the block being received
// S_RUN    | compression rounds, UNROLL per cycle
// S_UPDATE | fold working vars into chaining value, emit digest on last block
module sha2_multiblock_core #(
    parameter int MODE   = 512,
    parameter int T      = 0,
    parameter int UNROLL = 1,
    localparam int WIDTH       = (MODE == 224 || MODE == 256) ? 32 : 64,
    localparam int OUTPUT_SIZE = (T != 0) ? T : MODE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_first,
    input  logic                   in_last,
    output logic                   busy,
    output logic [OUTPUT_SIZE-1:0] digest,
    output logic                   digest_valid
);
    localparam logic [6:0] ROUNDS = (WIDTH == 32) ? 7'd64 : 7'd80;

    // SHA-256 round constants are the upper halves of the SHA-512 ones.
    localparam logic [63:0] K64 [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    // SHA-256 IV = upper halves of SHA-512 IV; SHA-224 IV = lower halves of SHA-384 IV.
    localparam logic [511:0] IV512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    localparam logic [511:0] IV384 = {
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
    localparam logic [511:0] IV512_224 = {
        64'h8c3d37c819544da2, 64'h73e1996689dcd4d6, 64'h1dfab7ae32ff9c82, 64'h679dd514582f9fcf,
        64'h0f6d2b697bd44da8, 64'h77e36f7304c48942, 64'h3f9d85a86a1d36c8, 64'h1112e6ad91d692a1};
    localparam logic [511:0] IV512_256 = {
        64'h22312194fc2bf72c, 64'h9f555fa3c84c64c2, 64'h2393b86b6f53b151, 64'h963877195940eabd,
        64'h96283ee2a88effe3, 64'hbe5e1e2553863992, 64'h2b0199fc2c85b8aa, 64'h0eb72ddc81c52ca2};
    localparam logic [511:0] IV_SEL = (MODE == 224 || MODE == 384) ? IV384 :
                                      (T == 224) ? IV512_224 :
                                      (T == 256) ? IV512_256 : IV512;
    localparam bit IV_LOW = (MODE == 224);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_UPDATE} state_t;

    state_t           state;
    logic [3:0]       wcnt;
    logic [6:0]       r;
    logic             last_q;
    logic [WIDTH-1:0] win [16];
    logic [WIDTH-1:0] wv  [8];
    logic [WIDTH-1:0] hc  [8];
    logic [WIDTH-1:0] iv  [8];
    logic [WIDTH-1:0] hc_sum [8];
    logic [8*WIDTH-1:0] hc_cat;
    logic [WIDTH-1:0] ext [16+UNROLL];
    logic [WIDTH-1:0] st  [UNROLL+1][8];

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int n);
        return (x >> n) | (x << (WIDTH - n));
    endfunction
    function automatic logic [WIDTH-1:0] bsig0(input logic [WIDTH-1:0] x);
        return (WIDTH == 32) ? (rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22))
                             : (rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39));
    endfunction
    function automatic logic [WIDTH-1:0] bsig1(input logic [WIDTH-1:0] x);
        return (WIDTH == 32) ? (rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25))
                             : (rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41));
    endfunction
    function automatic logic [WIDTH-1:0] ssig0(input logic [WIDTH-1:0] x);
        return (WIDTH == 32) ? (rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3))
                             : (rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7));
    endfunction
    function automatic logic [WIDTH-1:0] ssig1(input logic [WIDTH-1:0] x);
        return (WIDTH == 32) ? (rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10))
                             : (rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6));
    endfunction
    function automatic logic [WIDTH-1:0] k_of(input logic [6:0] idx);
        logic [63:0] kf;
        kf = K64[idx];
        return WIDTH'(kf >> (64 - WIDTH));
    endfunction

    // Initial hash value words and the chaining-value sum used by UPDATE.
    always_comb begin
        logic [63:0] ivw;
        ivw    = '0;
        hc_cat = '0;
        for (int i = 0; i < 8; i++) begin
            ivw       = IV_SEL[511-64*i -: 64];
            iv[i]     = IV_LOW ? WIDTH'(ivw) : WIDTH'(ivw >> (64 - WIDTH));
            hc_sum[i] = hc[i] + wv[i];
            hc_cat[(7-i)*WIDTH +: WIDTH] = hc_sum[i];
        end
    end

    // Message schedule: window holds W_r..W_r+15, extended by UNROLL new words.
    always_comb begin
        for (int j = 0; j < 16; j++) ext[j] = win[j];
        for (int j = 0; j < UNROLL; j++)
            ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
    end

    // UNROLL chained compression rounds starting at round r.
    always_comb begin
        logic [WIDTH-1:0] t1, t2;
        t1 = '0;
        t2 = '0;
        st[0] = wv;
        for (int i = 0; i < UNROLL; i++) begin
            t1 = st[i][7] + bsig1(st[i][4]) + ((st[i][4] & st[i][5]) ^ (~st[i][4] & st[i][6]))
               + k_of(r + 7'(i)) + ext[i];
            t2 = bsig0(st[i][0]) + ((st[i][0] & st[i][1]) ^ (st[i][0] & st[i][2]) ^ (st[i][1] & st[i][2]));
            st[i+1][0] = t1 + t2;
            st[i+1][1] = st[i][0];
            st[i+1][2] = st[i][1];
            st[i+1][3] = st[i][2];
            st[i+1][4] = st[i][3] + t1;
            st[i+1][5] = st[i][4];
            st[i+1][6] = st[i][5];
            st[i+1][7] = st[i][6];
        end
    end

    // Block sequencer: load, run rounds, update chaining value, emit digest.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            wcnt         <= '0;
            r            <= '0;
            last_q       <= 1'b0;
            hc           <= iv;
            digest       <= '0;
            digest_valid <= 1'b0;
            busy         <= 1'b0;
            in_ready     <= 1'b1;
            for (int j = 0; j < 16; j++) win[j] <= '0;
            for (int i = 0; i < 8; i++) wv[i] <= '0;
        end else begin
            digest_valid <= 1'b0;
            case (state)
                S_IDLE, S_LOAD: begin
                    if (in_valid && in_ready) begin
                        win[wcnt] <= in_data;
                        wcnt      <= wcnt + 4'd1;
                        if (wcnt == 4'd0) begin
                            busy  <= 1'b1;
                            state <= S_LOAD;
                            if (in_first) hc <= iv;
                        end
                        if (wcnt == 4'd15) begin
                            last_q   <= in_last;
                            state    <= S_RUN;
                            r        <= '0;
                            wv       <= hc;
                            in_ready <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    for (int j = 0; j < 16; j++) win[j] <= ext[UNROLL+j];
                    wv <= st[UNROLL];
                    r  <= r + 7'(UNROLL);
                    if (r + 7'(UNROLL) == ROUNDS) state <= S_UPDATE;
                end
                S_UPDATE: begin
                    hc <= hc_sum;
                    if (last_q) begin
                        digest       <= OUTPUT_SIZE'(hc_cat >> (8*WIDTH - OUTPUT_SIZE));
                        digest_valid <= 1'b1;
                    end
                    r        <= '0;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha2_multiblock_core.sv
// Directed bench for sha2_multiblock_core: five parameterisations fed with
// known-answer blocks; checks digests, latency, strobe width and abort.
module tb_sha2_multiblock_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [63:0]  d64;
    logic [31:0]  d32;
    logic         first, last;
    logic         v   [5];
    logic         rdy [5];
    logic         bsy [5];
    logic         dv  [5];
    logic [255:0] dg0, dg1, dg4;
    logic [511:0] dg2;
    logic [223:0] dg3;
    logic [511:0] dig [5];
    logic [63:0]  blk [16];
    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [511:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] TWO256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] ABC512 = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
    localparam logic [511:0] ABC224 = 224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;
    localparam logic [511:0] ABC512_256 = 256'h53048e2681941ef99b2e29b76b4c7dabe4c2d0c634fc6d46e0e2f13107e7af23;

    assign dig[0] = {256'b0, dg0};
    assign dig[1] = {256'b0, dg1};
    assign dig[2] = dg2;
    assign dig[3] = {288'b0, dg3};
    assign dig[4] = {256'b0, dg4};

    sha2_multiblock_core #(.MODE(256), .T(0), .UNROLL(1)) u0 (.clk(clk), .rst(rst), .in_data(d32),
        .in_valid(v[0]), .in_ready(rdy[0]), .in_first(first), .in_last(last), .busy(bsy[0]),
        .digest(dg0), .digest_valid(dv[0]));
    sha2_multiblock_core #(.MODE(256), .T(0), .UNROLL(4)) u1 (.clk(clk), .rst(rst), .in_data(d32),
        .in_valid(v[1]), .in_ready(rdy[1]), .in_first(first), .in_last(last), .busy(bsy[1]),
        .digest(dg1), .digest_valid(dv[1]));
    sha2_multiblock_core #(.MODE(512), .T(0), .UNROLL(2)) u2 (.clk(clk), .rst(rst), .in_data(d64),
        .in_valid(v[2]), .in_ready(rdy[2]), .in_first(first), .in_last(last), .busy(bsy[2]),
        .digest(dg2), .digest_valid(dv[2]));
    sha2_multiblock_core #(.MODE(224), .T(0), .UNROLL(1)) u3 (.clk(clk), .rst(rst), .in_data(d32),
        .in_valid(v[3]), .in_ready(rdy[3]), .in_first(first), .in_last(last), .busy(bsy[3]),
        .digest(dg3), .digest_valid(dv[3]));
    sha2_multiblock_core #(.MODE(512), .T(256), .UNROLL(1)) u4 (.clk(clk), .rst(rst), .in_data(d64),
        .in_valid(v[4]), .in_ready(rdy[4]), .in_first(first), .in_last(last), .busy(bsy[4]),
        .digest(dg4), .digest_valid(dv[4]));

    task automatic set_abc32();
        for (int k = 0; k < 16; k++) blk[k] = 64'h0;
        blk[0]  = 64'h61626380;
        blk[15] = 64'h18;
    endtask

    task automatic set_abc64();
        for (int k = 0; k < 16; k++) blk[k] = 64'h0;
        blk[0]  = 64'h6162638000000000;
        blk[15] = 64'h18;
    endtask

    // in_first / in_last are driven inverted on the words where they must be ignored.
    task automatic send_block(input int d, input logic f, input logic l, input bit gaps);
        int n;
        for (int k = 0; k < 16; k++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin @(negedge clk); v[d] = 1'b0; end
            end
            @(negedge clk);
            v[d]  = 1'b1;
            d64   = blk[k];
            d32   = blk[k][31:0];
            first = (k == 0)  ? f : ~f;
            last  = (k == 15) ? l : ~l;
            n = 0;
            while (!rdy[d] && n < 400) begin @(negedge clk); n++; end
            if (!rdy[d]) begin
                n_cmp++; n_bad++;
                $display("FAIL load_stall dut%0d word %0d: in_ready=0, required 1", d, k);
                v[d] = 1'b0;
                return;
            end
            @(posedge clk);
        end
        #1 v[d] = 1'b0;
    endtask

    task automatic wait_result(input int d, input int lat, input logic [511:0] exp, input string nm);
        int n;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!dv[d] && n < 300);
        n_cmp++;
        if (dv[d] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_timeout: digest_valid absent after %0d cycles, required at %0d", nm, n, lat);
            return;
        end
        n_cmp++;
        if (n !== lat) begin n_bad++; $display("FAIL %s_latency: got %0d cycles, required %0d", nm, n, lat); end
        n_cmp++;
        if (dig[d] !== exp) begin n_bad++; $display("FAIL %s_digest: got %h required %h", nm, dig[d], exp); end
        n_cmp++;
        if (rdy[d] !== 1'b1) begin n_bad++; $display("FAIL %s_ready: got %b required 1", nm, rdy[d]); end
        @(posedge clk); #1;
        n_cmp++;
        if (dv[d] !== 1'b0) begin n_bad++; $display("FAIL %s_pulse: digest_valid %b one cycle later, required 0", nm, dv[d]); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int d = 0; d < 5; d++) begin
            n_cmp++;
            if (rdy[d] !== 1'b1) begin n_bad++; $display("FAIL reset_ready dut%0d: got %b required 1", d, rdy[d]); end
            n_cmp++;
            if (bsy[d] !== 1'b0) begin n_bad++; $display("FAIL reset_busy dut%0d: got %b required 0", d, bsy[d]); end
            n_cmp++;
            if (dv[d] !== 1'b0) begin n_bad++; $display("FAIL reset_dv dut%0d: got %b required 0", d, dv[d]); end
            n_cmp++;
            if (dig[d] !== 512'h0) begin n_bad++; $display("FAIL reset_digest dut%0d: got %h required 0", d, dig[d]); end
        end
    endtask

    task automatic test_sha256_abc();
        set_abc32();
        send_block(0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (bsy[0] !== 1'b1 || rdy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL run_flags: busy=%b in_ready=%b, required busy=1 in_ready=0", bsy[0], rdy[0]);
        end
        wait_result(0, 65, ABC256, "sha256_abc");
    endtask

    task automatic test_unroll4();
        set_abc32();
        send_block(1, 1'b1, 1'b1, 1'b0);
        wait_result(1, 17, ABC256, "sha256_u4");
    endtask

    task automatic test_two_block();
        int n;
        bit seen;
        blk[0]  = 64'h61626364; blk[1]  = 64'h62636465; blk[2]  = 64'h63646566; blk[3]  = 64'h64656667;
        blk[4]  = 64'h65666768; blk[5]  = 64'h66676869; blk[6]  = 64'h6768696a; blk[7]  = 64'h68696a6b;
        blk[8]  = 64'h696a6b6c; blk[9]  = 64'h6a6b6c6d; blk[10] = 64'h6b6c6d6e; blk[11] = 64'h6c6d6e6f;
        blk[12] = 64'h6d6e6f70; blk[13] = 64'h6e6f7071; blk[14] = 64'h80000000; blk[15] = 64'h0;
        send_block(0, 1'b1, 1'b0, 1'b0);
        n = 0;
        seen = 1'b0;
        do begin @(posedge clk); #1; n++; if (dv[0]) seen = 1'b1; end while (!rdy[0] && n < 300);
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL two_block_early_dv: digest_valid seen after block 0, required none"); end
        n_cmp++;
        if (n !== 65) begin n_bad++; $display("FAIL two_block_ready_latency: got %0d cycles, required 65", n); end
        n_cmp++;
        if (dig[0] !== ABC256) begin n_bad++; $display("FAIL digest_hold: got %h required %h", dig[0], ABC256); end
        for (int k = 0; k < 15; k++) blk[k] = 64'h0;
        blk[15] = 64'h1c0;
        send_block(0, 1'b0, 1'b1, 1'b0);
        wait_result(0, 65, TWO256, "sha256_two_block");
    endtask

    task automatic test_sha512_gaps();
        set_abc64();
        send_block(2, 1'b1, 1'b1, 1'b1);
        wait_result(2, 41, ABC512, "sha512_gaps");
    endtask

    task automatic test_sha224();
        set_abc32();
        send_block(3, 1'b1, 1'b1, 1'b0);
        wait_result(3, 65, ABC224, "sha224_abc");
    endtask

    task automatic test_sha512_256();
        set_abc64();
        send_block(4, 1'b1, 1'b1, 1'b0);
        wait_result(4, 81, ABC512_256, "sha512_256_abc");
    endtask

    task automatic test_abort();
        bit seen;
        set_abc32();
        send_block(0, 1'b1, 1'b1, 1'b0);
        repeat (30) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        n_cmp++;
        if (bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_flags: busy=%b in_ready=%b, required busy=0 in_ready=1", bsy[0], rdy[0]);
        end
        n_cmp++;
        if (dig[0] !== 512'h0) begin n_bad++; $display("FAIL abort_digest: got %h required 0", dig[0]); end
        seen = 1'b0;
        repeat (60) begin @(posedge clk); #1; if (dv[0]) seen = 1'b1; end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL abort_pulse: digest_valid from aborted block, required none"); end
        send_block(0, 1'b0, 1'b1, 1'b0);
        wait_result(0, 65, ABC256, "abort_resend");
    endtask

    initial begin
        for (int d = 0; d < 5; d++) v[d] = 1'b0;
        d64 = '0; d32 = '0; first = 1'b0; last = 1'b0;
        test_reset();
        test_sha256_abc();
        test_unroll4();
        test_two_block();
        test_sha512_gaps();
        test_sha224();
        test_sha512_256();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
